// File: rtl/sp_pkg.sv
// Shared core parameters and types for the single-ported memory arbiter.
package sp_pkg;

  localparam int ADDR_WIDTH          = 16;
  localparam int ILEN                = 32;
  localparam int ARB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } arb_state_e;

endpackage

// File: rtl/arb_timeout_counter.sv
// Saturating busy-cycle counter; expired_o flags that LIMIT cycles passed without acknowledge.
module arb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_C = LIMIT[W-1:0];

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch (I) and load/store (D).
// state      | meaning
// ARB_IDLE   | no transaction outstanding; grant on next edge
// ARB_BUSY_I | fetch owns the memory until ack or timeout
// ARB_BUSY_D | load/store owns the memory until ack or timeout
module imem_dmem_arbiter
  import sp_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic [ILEN-1:0]       i_rdata_o,
  output logic                  i_ack_o,
  output logic                  i_err_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [BUS_WIDTH-1:0]  d_wdata_i,
  output logic [BUS_WIDTH-1:0]  d_rdata_o,
  output logic                  d_ack_o,
  output logic                  d_err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [BUS_WIDTH-1:0]  mem_wdata_o,
  input  logic [BUS_WIDTH-1:0]  mem_rdata_i,
  input  logic                  mem_ack_i
);

  arb_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;  // 1 = D port won last
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;

  logic grant_i, grant_d, busy, expired;

  assign grant_i = i_req_i && (!d_req_i || last_grant_q);
  assign grant_d = d_req_i && (!i_req_i || !last_grant_q);
  assign busy    = (state_q != ARB_IDLE);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_i) begin
          state_d      = ARB_BUSY_I;
          last_grant_d = 1'b0;
          addr_d       = i_addr_i;
          we_d         = 1'b0;
        end else if (grant_d) begin
          state_d      = ARB_BUSY_D;
          last_grant_d = 1'b1;
          addr_d       = d_addr_i;
          we_d         = d_we_i;
          wdata_d      = d_wdata_i;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (mem_ack_i || expired) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
    end
  end

  // Counter is held clear while idle, so each transaction starts from zero.
  arb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .clr_i     (!busy),
    .en_i      (busy && !mem_ack_i),
    .expired_o (expired)
  );

  assign mem_req_o   = busy;
  assign mem_we_o    = we_q && (state_q == ARB_BUSY_D);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign i_ack_o   = (state_q == ARB_BUSY_I) && mem_ack_i;
  assign d_ack_o   = (state_q == ARB_BUSY_D) && mem_ack_i;
  assign i_err_o   = (state_q == ARB_BUSY_I) && expired && !mem_ack_i;
  assign d_err_o   = (state_q == ARB_BUSY_D) && expired && !mem_ack_i;
  assign i_rdata_o = i_ack_o ? mem_rdata_i[ILEN-1:0] : '0;
  assign d_rdata_o = d_ack_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed scoreboard bench for imem_dmem_arbiter with a latency-programmable memory model.
module tb_imem_dmem_arbiter;
  import sp_pkg::*;

  localparam int BW  = 32;
  localparam int TMO = 4;
  localparam int NEVER = 1000;

  logic                  clk_i = 1'b0;
  logic                  arst_i = 1'b1;
  logic                  i_req_i = 1'b0;
  logic [ADDR_WIDTH-1:0] i_addr_i = '0;
  logic [ILEN-1:0]       i_rdata_o;
  logic                  i_ack_o, i_err_o;
  logic                  d_req_i = 1'b0;
  logic                  d_we_i = 1'b0;
  logic [ADDR_WIDTH-1:0] d_addr_i = '0;
  logic [BW-1:0]         d_wdata_i = '0;
  logic [BW-1:0]         d_rdata_o;
  logic                  d_ack_o, d_err_o;
  logic                  mem_req_o, mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [BW-1:0]         mem_wdata_o;
  logic [BW-1:0]         mem_rdata_i = '0;
  logic                  mem_ack_i = 1'b0;

  always #5 clk_i = ~clk_i;

  imem_dmem_arbiter #(
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .i_req_i     (i_req_i),
    .i_addr_i    (i_addr_i),
    .i_rdata_o   (i_rdata_o),
    .i_ack_o     (i_ack_o),
    .i_err_o     (i_err_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_rdata_o   (d_rdata_o),
    .d_ack_o     (d_ack_o),
    .d_err_o     (d_err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  // One expected transaction: who should win, what the memory sees, and how it ends.
  typedef struct {
    bit                    port_d;
    bit                    err;
    logic [ADDR_WIDTH-1:0] addr;
    bit                    we;
    logic [BW-1:0]         wdata;
    logic [BW-1:0]         data;
    int                    lat;
    int                    busy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;
  int done_age = 99;
  int i_left = 0;
  int d_left = 0;
  bit back_to_back = 1'b0;
  bit stray_ack = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit port_d, input bit err, input logic [ADDR_WIDTH-1:0] addr,
                      input bit we, input logic [BW-1:0] wdata, input logic [BW-1:0] data,
                      input int lat);
    exp_t e;
    e.port_d = port_d;
    e.err    = err;
    e.addr   = addr;
    e.we     = we;
    e.wdata  = wdata;
    e.data   = err ? '0 : data;
    e.lat    = lat;
    e.busy   = err ? TMO + 1 : lat + 1;
    q.push_back(e);
  endtask

  // One clock: model the memory, then check everything the DUT shows this cycle.
  task automatic cycle();
    exp_t e;
    logic [3:0] done_v, exp_v;
    @(posedge clk_i);
    #1;
    busy_cnt = mem_req_o ? busy_cnt + 1 : 0;
    done_age++;
    if (done_age == 1) chk("idle_after_done", 64'(mem_req_o), 64'd0);
    if (done_age == 2 && back_to_back && q.size() > 0) chk("restart_after_idle", 64'(mem_req_o), 64'd1);
    mem_ack_i = 1'b0;
    if (mem_req_o && q.size() > 0) mem_ack_i = (busy_cnt == q[0].lat + 1);
    if (!mem_req_o && stray_ack) mem_ack_i = 1'b1;
    mem_rdata_i = (mem_ack_i && mem_req_o && q.size() > 0) ? q[0].data : 32'h5A5A_A5A5;
    #1;
    if (mem_req_o) begin
      if (q.size() == 0) begin
        chk("req_without_txn", 64'(mem_req_o), 64'd0);
      end else begin
        chk("mem_addr", 64'(mem_addr_o), 64'(q[0].addr));
        chk("mem_we", 64'(mem_we_o), 64'(q[0].we));
        if (q[0].we) chk("mem_wdata", 64'(mem_wdata_o), 64'(q[0].wdata));
      end
    end
    if (!i_ack_o) chk("i_rdata_zero", 64'(i_rdata_o), 64'd0);
    if (!d_ack_o) chk("d_rdata_zero", 64'(d_rdata_o), 64'd0);
    done_v = {i_ack_o, i_err_o, d_ack_o, d_err_o};
    if (done_v != 4'b0000) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(done_v), 64'd0);
      end else begin
        e = q.pop_front();
        exp_v = e.port_d ? (e.err ? 4'b0001 : 4'b0010) : (e.err ? 4'b0100 : 4'b1000);
        chk("done_kind", 64'(done_v), 64'(exp_v));
        chk("done_busy_cycles", 64'(busy_cnt), 64'(e.busy));
        if (i_ack_o) chk("i_rdata", 64'(i_rdata_o), 64'(e.data[ILEN-1:0]));
        if (d_ack_o) chk("d_rdata", 64'(d_rdata_o), 64'(e.data));
        done_age = 0;
      end
      if (done_v[3:2] != 2'b00) begin
        i_left--;
        if (i_left <= 0) i_req_i = 1'b0;
      end
      if (done_v[1:0] != 2'b00) begin
        d_left--;
        if (d_left <= 0) d_req_i = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((q.size() > 0 || done_age < 2) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_completed"}, 64'(q.size() == 0), 64'd1);
    if (q.size() > 0) begin
      q.delete();
      i_req_i = 1'b0;
      d_req_i = 1'b0;
      i_left  = 0;
      d_left  = 0;
    end
  endtask

  task automatic do_reset();
    arst_i    = 1'b1;
    mem_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_mem_we", 64'(mem_we_o), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata_o), 64'd0);
    chk("rst_acks_errs", 64'({i_ack_o, i_err_o, d_ack_o, d_err_o}), 64'd0);
    @(negedge clk_i);
    arst_i   = 1'b0;
    busy_cnt = 0;
    done_age = 99;
  endtask

  initial begin
    int n;
    do_reset();

    // I-only fetch, memory acks three cycles after mem_req_o rises
    i_addr_i = 16'h0100;
    i_req_i  = 1'b1;
    i_left   = 1;
    push(1'b0, 1'b0, 16'h0100, 1'b0, '0, 32'h0000_ABCD, 3);
    wait_done("i_fetch", 40);

    // D write held stable until ack
    d_addr_i  = 16'h0200;
    d_wdata_i = 32'hDEAD_BEEF;
    d_we_i    = 1'b1;
    d_req_i   = 1'b1;
    d_left    = 1;
    push(1'b1, 1'b0, 16'h0200, 1'b1, 32'hDEAD_BEEF, 32'h0, 2);
    wait_done("d_write", 40);
    d_we_i = 1'b0;

    // Both requesting from reset: I first, then strict alternation
    do_reset();
    i_addr_i     = 16'h0110;
    d_addr_i     = 16'h0210;
    i_req_i      = 1'b1;
    d_req_i      = 1'b1;
    i_left       = 2;
    d_left       = 2;
    back_to_back = 1'b1;
    push(1'b0, 1'b0, 16'h0110, 1'b0, '0, 32'h1111_1111, 1);
    push(1'b1, 1'b0, 16'h0210, 1'b0, '0, 32'h2222_2222, 0);
    push(1'b0, 1'b0, 16'h0110, 1'b0, '0, 32'h3333_3333, 2);
    push(1'b1, 1'b0, 16'h0210, 1'b0, '0, 32'h4444_4444, 1);
    wait_done("round_robin", 80);
    back_to_back = 1'b0;

    // No acknowledge at all: D read times out
    d_addr_i = 16'h0300;
    d_req_i  = 1'b1;
    d_left   = 1;
    push(1'b1, 1'b1, 16'h0300, 1'b0, '0, '0, NEVER);
    wait_done("d_timeout", 40);

    // Ack lands on the cycle the counter expires: ack wins
    i_addr_i = 16'h0400;
    i_req_i  = 1'b1;
    i_left   = 1;
    push(1'b0, 1'b0, 16'h0400, 1'b0, '0, 32'h1234_5678, TMO);
    wait_done("ack_at_timeout", 40);

    // Stray acknowledge while idle must be ignored
    stray_ack = 1'b1;
    cycle();
    stray_ack = 1'b0;
    cycle();

    // Reset two cycles into a fetch aborts it silently
    i_addr_i = 16'h0500;
    i_req_i  = 1'b1;
    i_left   = 1;
    push(1'b0, 1'b0, 16'h0500, 1'b0, '0, '0, NEVER);
    n = 0;
    while (busy_cnt < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("abort_reached_busy", 64'(busy_cnt), 64'd2);
    arst_i = 1'b1;
    #1;
    chk("abort_mem_req", 64'(mem_req_o), 64'd0);
    chk("abort_no_done", 64'({i_ack_o, i_err_o, d_ack_o, d_err_o}), 64'd0);
    q.delete();
    i_req_i   = 1'b0;
    i_left    = 0;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    arst_i   = 1'b0;
    busy_cnt = 0;
    done_age = 99;
    cycle();
    chk("abort_stays_idle", 64'(mem_req_o), 64'd0);

    // Fresh request after the abort completes normally
    i_addr_i = 16'h0600;
    i_req_i  = 1'b1;
    i_left   = 1;
    push(1'b0, 1'b0, 16'h0600, 1'b0, '0, 32'hCAFE_F00D, 2);
    wait_done("post_reset_fetch", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
